// File: rtl/weight_bank_pingpong.sv
// -----------------------------------------------------------------------------
// weight_bank_pingpong
//
// Double-buffered (ping/pong) weight store for the conv datapath. Each of the
// NUM_BANKS lanes is one array of 2*DEPTH words addressed as {half, addr}. The
// loader fills half fill_half while the datapath reads half rd_half, so the
// next layer's weights stream in while the current layer computes.
//
// Ports
//   clk, rst        clock, synchronous active-high reset
//   wr_valid/ready  write handshake (ready while the fill half is not full)
//   wr_bank         target lane (ignored when wr_bcast)
//   wr_bcast        write wr_data into every lane
//   wr_addr/data    word address within the fill half, write data
//   wr_done         pulse: fill half complete, mark full and swap fill half
//   rd_valid        read request (accepted only while weights_ready)
//   rd_mask         lanes to read; masked-off lanes return zero
//   rd_addr         word address within the read half
//   rd_release      pulse: read half consumed, mark empty and swap read half
//   weights_ready   read half is full
//   rd_data         lane i at [i*LANE_WIDTH +: LANE_WIDTH]
//   rd_data_valid   one cycle per accepted read, READ_LATENCY cycles later
//   buf_full        full flag per half
//   fill_half       half being written
//   rd_half         half being read
//   rd_err          sticky: read issued while !weights_ready
// -----------------------------------------------------------------------------
module weight_bank_pingpong #(
  parameter int NUM_BANKS    = 8,
  parameter int LANE_WIDTH   = 72,
  parameter int DEPTH        = 1024,
  parameter int READ_LATENCY = 3,
  parameter int ADDR_WIDTH   = $clog2(DEPTH),
  parameter int BSEL_WIDTH   = (NUM_BANKS > 1) ? $clog2(NUM_BANKS) : 1
) (
  input  logic                            clk,
  input  logic                            rst,
  input  logic                            wr_valid,
  output logic                            wr_ready,
  input  logic [BSEL_WIDTH-1:0]           wr_bank,
  input  logic                            wr_bcast,
  input  logic [ADDR_WIDTH-1:0]           wr_addr,
  input  logic [LANE_WIDTH-1:0]           wr_data,
  input  logic                            wr_done,
  input  logic                            rd_valid,
  input  logic [NUM_BANKS-1:0]            rd_mask,
  input  logic [ADDR_WIDTH-1:0]           rd_addr,
  input  logic                            rd_release,
  output logic                            weights_ready,
  output logic [NUM_BANKS*LANE_WIDTH-1:0] rd_data,
  output logic                            rd_data_valid,
  output logic [1:0]                      buf_full,
  output logic                            fill_half,
  output logic                            rd_half,
  output logic                            rd_err
);

  localparam int DATA_W     = NUM_BANKS * LANE_WIDTH;
  localparam int PHYS_DEPTH = 2 * DEPTH;

  // Status registers
  logic [1:0] r_buf_full;
  logic       r_fill_half;
  logic       r_rd_half;
  logic       r_rd_err;

  // Storage: one array per lane, half selected by the address MSB
  logic [LANE_WIDTH-1:0] r_mem [NUM_BANKS][PHYS_DEPTH];

  // Read pipeline: stage 0 holds the (masked) array output, the last stage
  // drives the ports. Data stages load only behind a valid so the output
  // holds its last value between reads.
  logic [READ_LATENCY-1:0] r_vld;
  logic [DATA_W-1:0]       r_dat [READ_LATENCY];

  logic                  w_wr_ready;
  logic                  w_weights_ready;
  logic                  w_wr_fire;
  logic                  w_done_fire;
  logic                  w_rd_fire;
  logic                  w_rel_fire;
  logic [ADDR_WIDTH:0]   w_wr_paddr;
  logic [ADDR_WIDTH:0]   w_rd_paddr;
  logic [1:0]            w_buf_full_nxt;

  // Reads need a full half and writes need a non-full half, so the two ports
  // can never touch the same half in the same cycle.
  assign w_wr_ready      = !r_buf_full[r_fill_half];
  assign w_weights_ready = r_buf_full[r_rd_half];
  assign w_wr_fire       = wr_valid   & w_wr_ready;
  assign w_done_fire     = wr_done    & w_wr_ready;
  assign w_rd_fire       = rd_valid   & w_weights_ready;
  assign w_rel_fire      = rd_release & w_weights_ready;
  assign w_wr_paddr      = {r_fill_half, wr_addr};
  assign w_rd_paddr      = {r_rd_half, rd_addr};

  // Release is applied first so a done aimed at the same half wins.
  always_comb begin
    // NOTE: combinational logic uses blocking '=' and assigns a default first,
    // so every path drives the output and no latch is inferred.
    w_buf_full_nxt = r_buf_full;
    if (w_rel_fire)  w_buf_full_nxt[r_rd_half]   = 1'b0;
    if (w_done_fire) w_buf_full_nxt[r_fill_half] = 1'b1;
  end

  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking '<=' so every register samples
    // pre-edge values regardless of statement order.
    if (rst) begin
      r_buf_full  <= 2'b00;
      r_fill_half <= 1'b0;
      r_rd_half   <= 1'b0;
      r_rd_err    <= 1'b0;
    end else begin
      r_buf_full  <= w_buf_full_nxt;
      r_fill_half <= r_fill_half ^ w_done_fire;
      r_rd_half   <= r_rd_half ^ w_rel_fire;
      r_rd_err    <= r_rd_err | (rd_valid & !w_weights_ready);
    end
  end

  // NOTE: the weight arrays are deliberately left out of reset; clearing a
  // RAM needs a per-word sequencer and blocks block-RAM/URAM mapping.
  // A write with wr_bank >= NUM_BANKS matches no lane and is dropped.
  always_ff @(posedge clk) begin
    for (int b = 0; b < NUM_BANKS; b++) begin
      if (w_wr_fire && (wr_bcast || (wr_bank == BSEL_WIDTH'(b)))) begin
        r_mem[b][w_wr_paddr] <= wr_data;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_vld <= '0;
      for (int s = 0; s < READ_LATENCY; s++) r_dat[s] <= '0;
    end else begin
      r_vld[0] <= w_rd_fire;
      if (w_rd_fire) begin
        for (int b = 0; b < NUM_BANKS; b++) begin
          r_dat[0][b*LANE_WIDTH +: LANE_WIDTH] <=
            rd_mask[b] ? r_mem[b][w_rd_paddr] : '0;
        end
      end
      for (int s = 1; s < READ_LATENCY; s++) begin
        r_vld[s] <= r_vld[s-1];
        if (r_vld[s-1]) r_dat[s] <= r_dat[s-1];
      end
    end
  end

  assign wr_ready      = w_wr_ready;
  assign weights_ready = w_weights_ready;
  assign rd_data       = r_dat[READ_LATENCY-1];
  assign rd_data_valid = r_vld[READ_LATENCY-1];
  assign buf_full      = r_buf_full;
  assign fill_half     = r_fill_half;
  assign rd_half       = r_rd_half;
  assign rd_err        = r_rd_err;

endmodule
